// File: rtl/vend_pkg.sv
// Shared types for the vending machine FSM and its dispenser stage.
// Holds the change codes, dispenser state enum and FIFO entry payload.
package vend_pkg;

  typedef enum logic [1:0] {
    CHG_NONE = 2'b00,
    CHG_50   = 2'b01,
    CHG_100  = 2'b10,
    CHG_ILL  = 2'b11
  } change_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_MOTOR = 2'b01,
    ST_COIN  = 2'b10,
    ST_GAP   = 2'b11
  } disp_state_t;

  typedef struct packed {
    logic    vend;
    change_t change;
  } vend_entry_t;

  // The illegal code is treated as "no change".
  function automatic change_t sanitize_change(input logic [1:0] c);
    return (c == 2'b11) ? CHG_NONE : change_t'(c);
  endfunction

endpackage

// File: rtl/vend_event_fifo.sv
// Synchronous event FIFO for the dispenser; push and pop may happen in the
// same cycle even when full.
// Ports: clk, rst (sync, active-high), push/din, pop/dout, full, empty, count.
module vend_event_fifo
  import vend_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  vend_entry_t   din,
  input  logic          pop,
  output vend_entry_t   dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  vend_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  // A pop frees a slot in the same cycle, so a push while full is kept.
  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/vend_dispenser.sv
// Vend dispenser: turns bottle/change requests from the vending FSM into
// queued events and drives the motor and coin solenoids with fixed,
// non-overlapping pulses followed by an all-off gap.
// Ports: clk, rst (sync, active-high), vend, change[1:0] in;
//        motor, coin50, coin100, busy, overflow, illegal, dispensed_cnt[7:0] out.
// Build option: VEND_CHANGE_SPLIT_EN pays 100rs change as two 50rs pulses
// separated by a gap, and ties coin100 low.
module vend_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned MOTOR_CYCLES = 8,
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vend,
  input  logic [1:0] change,
  output logic       motor,
  output logic       coin50,
  output logic       coin100,
  output logic       busy,
  output logic       overflow,
  output logic       illegal,
  output logic [7:0] dispensed_cnt
);

  localparam int unsigned MAX_MP = (MOTOR_CYCLES > PULSE_CYCLES) ? MOTOR_CYCLES : PULSE_CYCLES;
  localparam int unsigned MAX_P  = (MAX_MP > GAP_CYCLES) ? MAX_MP : GAP_CYCLES;
  localparam int unsigned TW     = $clog2(MAX_P + 1);
  localparam int unsigned QW     = $clog2(FIFO_DEPTH) + 1;

  vend_entry_t   sample;
  vend_entry_t   prev_q;
  vend_entry_t   head;
  vend_entry_t   cur_q;
  vend_entry_t   cur_n;
  disp_state_t   state;
  disp_state_t   state_n;
  logic [TW-1:0] tmr;
  logic [TW-1:0] tmr_n;
  logic          event_c;
  logic          pop;
  logic          push_ok;
  logic          full;
  logic          empty;
  logic [QW-1:0] q_count;
  logic [QW-1:0] q_count_n;
  logic          motor_d;
  logic          coin50_d;
  logic          coin100_d;
  logic          busy_d;
  logic          overflow_d;
  logic          illegal_d;
  logic [7:0]    dispensed_d;
`ifdef VEND_CHANGE_SPLIT_EN
  logic          half_q;
  logic          half_n;
`endif

  // Edge detect on the sanitized request: a held value is one event.
  always_comb begin
    sample.vend   = vend;
    sample.change = sanitize_change(change);
  end

  assign event_c   = (sample != '0) && (sample != prev_q);
  assign push_ok   = event_c && (!full || pop);
  assign q_count_n = q_count + QW'(push_ok) - QW'(pop);

  vend_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (event_c),
    .din   (sample),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (q_count)
  );

  // State register, phase timer and the entry being served.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      tmr    <= '0;
      cur_q  <= '0;
      prev_q <= '0;
`ifdef VEND_CHANGE_SPLIT_EN
      half_q <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      tmr    <= tmr_n;
      cur_q  <= cur_n;
      prev_q <= sample;
`ifdef VEND_CHANGE_SPLIT_EN
      half_q <= half_n;
`endif
    end
  end

  // Next state; the timer is reloaded on every state entry.
  always_comb begin
    state_n = state;
    tmr_n   = (tmr != '0) ? tmr - TW'(1) : tmr;
    cur_n   = cur_q;
    pop     = 1'b0;
`ifdef VEND_CHANGE_SPLIT_EN
    half_n  = half_q;
`endif
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop   = 1'b1;
          cur_n = head;
`ifdef VEND_CHANGE_SPLIT_EN
          half_n = 1'b0;
`endif
          if (head.vend) begin
            state_n = ST_MOTOR;
            tmr_n   = TW'(MOTOR_CYCLES - 1);
          end else begin
            state_n = ST_COIN;
            tmr_n   = TW'(PULSE_CYCLES - 1);
          end
        end
      end
      ST_MOTOR: begin
        if (tmr == '0) begin
          if (cur_q.change != CHG_NONE) begin
            state_n = ST_COIN;
            tmr_n   = TW'(PULSE_CYCLES - 1);
          end else begin
            state_n = ST_GAP;
            tmr_n   = TW'(GAP_CYCLES - 1);
          end
        end
      end
      ST_COIN: begin
        if (tmr == '0) begin
          state_n = ST_GAP;
          tmr_n   = TW'(GAP_CYCLES - 1);
        end
      end
      ST_GAP: begin
        if (tmr == '0) begin
`ifdef VEND_CHANGE_SPLIT_EN
          // Second half of a split 100rs payout.
          if ((cur_q.change == CHG_100) && !half_q) begin
            half_n  = 1'b1;
            state_n = ST_COIN;
            tmr_n   = TW'(PULSE_CYCLES - 1);
          end else
`endif
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Output next values; drives follow the state one cycle later.
  always_comb begin
    motor_d   = (state == ST_MOTOR);
    coin50_d  = 1'b0;
    coin100_d = 1'b0;
    if (state == ST_COIN) begin
`ifdef VEND_CHANGE_SPLIT_EN
      coin50_d  = (cur_q.change == CHG_50) || (cur_q.change == CHG_100);
`else
      coin50_d  = (cur_q.change == CHG_50);
      coin100_d = (cur_q.change == CHG_100);
`endif
    end
    busy_d      = (state_n != ST_IDLE) || (q_count_n != '0);
    overflow_d  = overflow || (event_c && full && !pop);
    illegal_d   = illegal || (change == 2'b11);
    dispensed_d = dispensed_cnt;
    if ((state == ST_MOTOR) && (tmr == '0) && (dispensed_cnt != 8'hFF)) begin
      dispensed_d = dispensed_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      motor         <= 1'b0;
      coin50        <= 1'b0;
      coin100       <= 1'b0;
      busy          <= 1'b0;
      overflow      <= 1'b0;
      illegal       <= 1'b0;
      dispensed_cnt <= 8'd0;
    end else begin
      motor         <= motor_d;
      coin50        <= coin50_d;
      coin100       <= coin100_d;
      busy          <= busy_d;
      overflow      <= overflow_d;
      illegal       <= illegal_d;
      dispensed_cnt <= dispensed_d;
    end
  end

endmodule

// File: tb/tb_vend_dispenser.sv
// Self-checking bench for vend_dispenser: directed scenarios followed by a
// randomized phase, all compared every cycle against a timeline model.
module tb_vend_dispenser;

  localparam int unsigned M = 8;
  localparam int unsigned C = 4;
  localparam int unsigned G = 2;
  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       vend;
  logic [1:0] change;
  logic       motor;
  logic       coin50;
  logic       coin100;
  logic       busy;
  logic       overflow;
  logic       illegal;
  logic [7:0] dispensed_cnt;

  always #5 clk = ~clk;

  vend_dispenser #(
    .MOTOR_CYCLES (M),
    .PULSE_CYCLES (C),
    .GAP_CYCLES   (G),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .vend          (vend),
    .change        (change),
    .motor         (motor),
    .coin50        (coin50),
    .coin100       (coin100),
    .busy          (busy),
    .overflow      (overflow),
    .illegal       (illegal),
    .dispensed_cnt (dispensed_cnt)
  );

  // Reference model: event queue plus the schedule of the entry in service.
  int         t;
  logic [2:0] m_prev;
  logic [2:0] q[$];
  bit         act;
  int         p_edge;
  logic [2:0] a_ent;
  int         a_len;
  int         next_free;
  int         m_cnt;
  bit         m_ovf;
  bit         m_ill;

  int checks;
  int failures;
  int motor_hi;
  int c50_hi;
  int c100_hi;
  int base_cnt;

  function automatic int coin_len(input logic [1:0] ch);
    if (ch == 2'd0) return 0;
`ifdef VEND_CHANGE_SPLIT_EN
    if (ch == 2'd2) return 2 * C + G;
`endif
    return C;
  endfunction

  function automatic int svc_len(input logic [2:0] e);
    return (e[2] ? M : 0) + coin_len(e[1:0]) + G;
  endfunction

  task automatic model_edge(input logic v, input logic [1:0] ch, input logic r);
    logic [1:0] cs;
    logic [2:0] s;
    bit         can_pop;
    if (r) begin
      q.delete();
      act       = 1'b0;
      next_free = 0;
      m_prev    = 3'd0;
      m_cnt     = 0;
      m_ovf     = 1'b0;
      m_ill     = 1'b0;
    end else begin
      if (act && a_ent[2] && (t == p_edge + M) && (m_cnt < 255)) m_cnt++;
      can_pop = (q.size() > 0) && (t >= next_free);
      if (ch == 2'd3) m_ill = 1'b1;
      cs = (ch == 2'd3) ? 2'd0 : ch;
      s  = {v, cs};
      if (can_pop) begin
        a_ent     = q.pop_front();
        act       = 1'b1;
        p_edge    = t;
        a_len     = svc_len(a_ent);
        next_free = t + a_len + 1;
      end
      if ((s != 3'd0) && (s != m_prev)) begin
        if (q.size() < D) q.push_back(s);
        else m_ovf = 1'b1;
      end
      m_prev = s;
    end
  endtask

  task automatic expect_drives(output bit em, output bit e50, output bit e100);
    int o;
    int cs;
    em   = 1'b0;
    e50  = 1'b0;
    e100 = 1'b0;
    if (act) begin
      o  = t - p_edge;
      cs = a_ent[2] ? M : 0;
      if (a_ent[2] && (o >= 1) && (o <= M)) em = 1'b1;
      if ((a_ent[1:0] == 2'd1) && (o > cs) && (o <= cs + C)) e50 = 1'b1;
      if (a_ent[1:0] == 2'd2) begin
`ifdef VEND_CHANGE_SPLIT_EN
        if (((o > cs) && (o <= cs + C)) || ((o > cs + C + G) && (o <= cs + 2 * C + G))) e50 = 1'b1;
`else
        if ((o > cs) && (o <= cs + C)) e100 = 1'b1;
`endif
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [1:0] ch, input logic r);
    bit em;
    bit e50;
    bit e100;
    bit eb;
    vend   = v;
    change = ch;
    rst    = r;
    @(posedge clk);
    t++;
    model_edge(v, ch, r);
    @(negedge clk);
    expect_drives(em, e50, e100);
    eb = (q.size() > 0) || (act && (t < p_edge + a_len));
    chk("motor",     {7'd0, motor},    {7'd0, em});
    chk("coin50",    {7'd0, coin50},   {7'd0, e50});
    chk("coin100",   {7'd0, coin100},  {7'd0, e100});
    chk("busy",      {7'd0, busy},     {7'd0, eb});
    chk("overflow",  {7'd0, overflow}, {7'd0, m_ovf});
    chk("illegal",   {7'd0, illegal},  {7'd0, m_ill});
    chk("dispensed", dispensed_cnt,    8'(m_cnt));
    if (motor === 1'b1) motor_hi++;
    if (coin50 === 1'b1) c50_hi++;
    if (coin100 === 1'b1) c100_hi++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0);
  endtask

  task automatic clr_hi();
    motor_hi = 0;
    c50_hi   = 0;
    c100_hi  = 0;
  endtask

  initial begin
    logic       rv;
    logic [1:0] rc;
    t        = 0;
    checks   = 0;
    failures = 0;
    vend     = 1'b0;
    change   = 2'd0;
    rst      = 1'b1;
    model_edge(1'b0, 2'd0, 1'b1);
    clr_hi();

    // Reset state.
    step(1'b0, 2'd0, 1'b1);
    step(1'b0, 2'd0, 1'b1);
    chk("rst_dispensed", dispensed_cnt, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);

    // Single bottle: 8 motor cycles, count 1, busy drops.
    clr_hi();
    step(1'b1, 2'd0, 1'b0);
    idle(14);
    chk("t1_motor_len", 8'(motor_hi), 8'd8);
    chk("t1_dispensed", dispensed_cnt, 8'd1);
    chk("t1_busy_low", {7'd0, busy}, 8'd0);

    // Bottle plus 100rs change.
    clr_hi();
    step(1'b1, 2'd2, 1'b0);
    idle(26);
    chk("t2_motor_len", 8'(motor_hi), 8'd8);
`ifdef VEND_CHANGE_SPLIT_EN
    chk("t2_coin50_len", 8'(c50_hi), 8'd8);
    chk("t2_coin100_len", 8'(c100_hi), 8'd0);
`else
    chk("t2_coin50_len", 8'(c50_hi), 8'd0);
    chk("t2_coin100_len", 8'(c100_hi), 8'd4);
`endif

    // Held 50rs request is one event.
    clr_hi();
    for (int i = 0; i < 5; i++) step(1'b0, 2'd1, 1'b0);
    idle(12);
    chk("t3_coin50_len", 8'(c50_hi), 8'd4);
    chk("t3_motor_len", 8'(motor_hi), 8'd0);

    // Six back-to-back events with depth 4: the sixth is dropped.
    base_cnt = int'(dispensed_cnt);
    step(1'b1, 2'd0, 1'b0);
    step(1'b0, 2'd1, 1'b0);
    step(1'b1, 2'd0, 1'b0);
    step(1'b0, 2'd1, 1'b0);
    step(1'b1, 2'd2, 1'b0);
    step(1'b0, 2'd2, 1'b0);
    chk("t4_overflow", {7'd0, overflow}, 8'd1);
    idle(100);
    chk("t4_dispensed", dispensed_cnt, 8'(base_cnt + 3));
    chk("t4_busy_low", {7'd0, busy}, 8'd0);

    // Illegal change: flag only, then a bottle is still served.
    clr_hi();
    step(1'b0, 2'd3, 1'b0);
    idle(6);
    chk("t5_illegal", {7'd0, illegal}, 8'd1);
    chk("t5_no_drive", 8'(motor_hi + c50_hi + c100_hi), 8'd0);
    step(1'b1, 2'd0, 1'b0);
    idle(14);
    chk("t5_motor_len", 8'(motor_hi), 8'd8);

    // Reset during the 4th motor cycle with events still queued.
    step(1'b1, 2'd0, 1'b0);
    step(1'b0, 2'd1, 1'b0);
    step(1'b1, 2'd0, 1'b0);
    idle(3);
    chk("t6_motor_on", {7'd0, motor}, 8'd1);
    chk("t6_fifo_busy", {7'd0, dut.u_fifo.empty}, 8'd0);
    step(1'b0, 2'd0, 1'b1);
    chk("t6_motor_off", {7'd0, motor}, 8'd0);
    chk("t6_busy", {7'd0, busy}, 8'd0);
    chk("t6_dispensed", dispensed_cnt, 8'd0);
    chk("t6_fifo_empty", {7'd0, dut.u_fifo.empty}, 8'd1);
    idle(5);

    // Random phase with occasional resets.
    rv = 1'b0;
    rc = 2'd0;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 9) < 6) begin
          rv = 1'b0;
          rc = 2'd0;
        end else begin
          rv = 1'($urandom_range(0, 1));
          rc = 2'($urandom_range(0, 3));
        end
      end
      step(rv, rc, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
    end

    // Saturation of the bottle counter.
    step(1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 258; i++) begin
      step(1'b1, 2'd0, 1'b0);
      idle(11);
    end
    chk("sat_dispensed", dispensed_cnt, 8'd255);
    chk("sat_overflow", {7'd0, overflow}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
